// File: rtl/div_seq_ctrl_pkg.sv
// Shared ALU opcode constants plus the divide sequencer state type and latency.
package div_seq_ctrl_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] OPADD  = 5'd0;
   localparam logic [4:0] OPSUB  = 5'd1;
   localparam logic [4:0] OPAND  = 5'd2;
   localparam logic [4:0] OPOR   = 5'd3;
   localparam logic [4:0] OPDIV  = 5'd10;
   localparam logic [4:0] OPDIVU = 5'd11;
   localparam logic [4:0] OPREM  = 5'd12;
   localparam logic [4:0] OPREMU = 5'd13;

   localparam logic [XLEN-1:0] ZERO = '0;

   // Acceptance edge to oDone on the iterative path: XLEN CALC cycles, one FIX, one DONE.
   localparam int DIV_LATENCY = 34;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
   endfunction

endpackage

// File: rtl/div_seq_ctrl_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_restoring_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < div always holds, so the top bit of the WIDTH+1 trial is a clean borrow flag.
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      trial   = shifted - {1'b0, div_i};
      if (!trial[WIDTH]) begin
         rem_o = trial[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer with start/busy/done handshake and kill.
module div_seq_ctrl
   import div_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [4:0]       iControl,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iKill,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oResult
);

   div_state_t       state_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, res_q;
   logic [WIDTH-1:0] rem_d, quo_d;
   logic [CNT_W-1:0] cnt_q;
   logic             is_rem_q, neg_q, busy_q, done_q;

   logic             signed_op, a_neg, b_neg, op_rem;
   logic             div_zero, sgn_ovf, fast, accept;
   logic [WIDTH-1:0] a_abs, b_abs, fast_res, fix_sel, fix_res;

   always_comb begin
      signed_op = (iControl == OPDIV) || (iControl == OPREM);
      op_rem    = (iControl == OPREM) || (iControl == OPREMU);
      a_neg     = signed_op & iA[WIDTH-1];
      b_neg     = signed_op & iB[WIDTH-1];
      a_abs     = a_neg ? -iA : iA;
      b_abs     = b_neg ? -iB : iB;
      div_zero  = (iB == '0);
      sgn_ovf   = signed_op && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
      fast      = div_zero | sgn_ovf;
      accept    = (state_q == IDLE) & iStart & ~iKill & is_div_op(iControl);
      // Corner results follow RISC-V: x/0 = all-ones, x%0 = x, MIN/-1 = MIN, MIN%-1 = 0.
      if (div_zero) fast_res = op_rem ? iA : '1;
      else          fast_res = op_rem ? '0 : iA;
      fix_sel   = is_rem_q ? rem_q : quo_q;
      fix_res   = neg_q ? -fix_sel : fix_sel;
   end

   div_restoring_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (dvs_q),
      .rem_o (rem_d),
      .quo_o (quo_d)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         is_rem_q <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  busy_q   <= 1'b1;
                  is_rem_q <= op_rem;
                  neg_q    <= op_rem ? a_neg : (a_neg ^ b_neg);
                  dvs_q    <= b_abs;
                  rem_q    <= '0;
                  quo_q    <= a_abs;
                  cnt_q    <= CNT_W'(WIDTH);
                  if (fast) begin
                     res_q   <= fast_res;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (iKill) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) state_q <= FIX;
               end
            end
            FIX: begin
               if (iKill) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  res_q   <= fix_res;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign oBusy   = busy_q;
   assign oDone   = done_q;
   assign oResult = res_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomized checks of div_seq_ctrl against a behavioural reference.
module tb_div_seq_ctrl;
   import div_seq_ctrl_pkg::*;

   logic        iCLK = 1'b0;
   logic        iRST, iStart, iKill;
   logic [4:0]  iControl;
   logic [31:0] iA, iB;
   logic        oBusy, oDone;
   logic [31:0] oResult;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_res;

   div_seq_ctrl dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iStart   (iStart),
      .iControl (iControl),
      .iA       (iA),
      .iB       (iB),
      .iKill    (iKill),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oResult  (oResult)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OPDIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         OPREM:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         OPDIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      sgn = (op == OPDIV) || (op == OPREM);
      if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return DIV_LATENCY;
   endfunction

   // Drive a request and return in the first busy cycle (cycle 1 after acceptance).
   task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int waits);
      @(negedge iCLK);
      iStart = 1'b1; iControl = op; iA = a; iB = b;
      waits = 0;
      do begin
         @(posedge iCLK); #1;
         waits++;
      end while (!oBusy && waits < 6);
      iStart = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat,
                            input int lat0);
      int lat;
      lat = lat0;
      while (!oDone && lat < 60) begin
         @(posedge iCLK); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " result"}, oResult, exp);
      last_res = exp;
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_wait);
      int w;
      start_op(op, a, b, w);
      if (exp_wait != 0) chk({tag, " accept wait"}, w, exp_wait);
      wait_done(tag, ref_op(op, a, b), ref_lat(op, a, b), 1);
   endtask

   initial begin
      int          w, ndone;
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [4:0]  ops [4];
      ops = '{OPDIV, OPDIVU, OPREM, OPREMU};

      iRST = 1'b1; iStart = 1'b0; iKill = 1'b0; iControl = OPADD; iA = '0; iB = '0;
      repeat (2) @(posedge iCLK);
      #1;
      chk("reset busy", oBusy, 0);
      chk("reset done", oDone, 0);
      chk("reset result", oResult, 0);
      iRST = 1'b0;

      // Hand-computed directed vectors.
      start_op(OPDIV, 32'd7, 32'hFFFF_FFFE, w);
      wait_done("div 7/-2", 32'hFFFF_FFFD, 34, 1);
      start_op(OPREM, 32'd7, 32'hFFFF_FFFE, w);
      wait_done("rem 7%-2", 32'h1, 34, 1);
      start_op(OPREM, 32'hFFFF_FFF9, 32'd2, w);
      wait_done("rem -7%2", 32'hFFFF_FFFF, 34, 1);
      start_op(OPDIVU, 32'hFFFF_FFFF, 32'd2, w);
      wait_done("divu max/2", 32'h7FFF_FFFF, 34, 1);
      start_op(OPREMU, 32'hFFFF_FFFF, 32'd2, w);
      wait_done("remu max%2", 32'h1, 34, 1);

      @(posedge iCLK); #1;
      chk("hold done low", oDone, 0);
      chk("hold result", oResult, 32'h1);
      chk("idle busy low", oBusy, 0);

      start_op(OPDIV, 32'd5, 32'd0, w);
      wait_done("div 5/0", 32'hFFFF_FFFF, 1, 1);
      start_op(OPREMU, 32'd5, 32'd0, w);
      wait_done("remu 5%0", 32'd5, 1, 1);
      start_op(OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, w);
      wait_done("div ovf", 32'h8000_0000, 1, 1);
      start_op(OPREM, 32'h8000_0000, 32'hFFFF_FFFF, w);
      wait_done("rem ovf", 32'h0, 1, 1);

      // Non-divide opcode is ignored.
      @(negedge iCLK);
      iStart = 1'b1; iControl = OPADD; iA = 32'd3; iB = 32'd4;
      ndone = 0; w = 0;
      repeat (4) begin
         @(posedge iCLK); #1;
         if (oDone) ndone++;
         if (oBusy) w++;
      end
      iStart = 1'b0;
      chk("opadd busy cycles", w, 0);
      chk("opadd done count", ndone, 0);

      // Kill beats start in IDLE.
      @(negedge iCLK);
      iStart = 1'b1; iKill = 1'b1; iControl = OPDIV; iA = 32'd9; iB = 32'd3;
      @(posedge iCLK); #1;
      iStart = 1'b0; iKill = 1'b0;
      chk("kill+start busy", oBusy, 0);

      // Start pulsed during CALC is ignored.
      start_op(OPDIVU, 32'd100, 32'd7, w);
      repeat (4) begin @(posedge iCLK); #1; end
      iStart = 1'b1; iControl = OPREM; iA = 32'd5; iB = 32'd0;
      @(posedge iCLK); #1;
      iStart = 1'b0;
      chk("calc start ignored busy", oBusy, 1);
      wait_done("divu 100/7 w/ stray start", 32'd14, 34, 6);

      // Back-to-back: second request accepted in the IDLE cycle after DONE.
      run_op("b2b div -100/7", OPDIV, 32'hFFFF_FF9C, 32'd7, 2);
      run_op("b2b remu 1000/7", OPREMU, 32'd1000, 32'd7, 2);

      // Kill at cycle 10.
      start_op(OPDIVU, 32'd1000, 32'd3, w);
      repeat (9) begin @(posedge iCLK); #1; end
      iKill = 1'b1;
      @(posedge iCLK); #1;
      iKill = 1'b0;
      chk("kill busy", oBusy, 0);
      chk("kill result held", oResult, last_res);
      ndone = 0;
      repeat (40) begin @(posedge iCLK); #1; if (oDone) ndone++; end
      chk("kill no done", ndone, 0);

      // Reset at cycle 20.
      start_op(OPDIV, 32'hFFFF_FF9C, 32'd7, w);
      repeat (19) begin @(posedge iCLK); #1; end
      iRST = 1'b1; iKill = 1'b1;
      @(posedge iCLK); #1;
      iRST = 1'b0; iKill = 1'b0;
      chk("mid reset busy", oBusy, 0);
      chk("mid reset done", oDone, 0);
      chk("mid reset result", oResult, 0);
      ndone = 0;
      repeat (40) begin @(posedge iCLK); #1; if (oDone) ndone++; end
      chk("mid reset no done", ndone, 0);

      // Randomized operands against the reference model, all back-to-back.
      for (int i = 0; i < 200; i++) begin
         op = ops[$urandom_range(0, 3)];
         case ($urandom_range(0, 7))
            0:       a = 32'h8000_0000;
            1:       a = $urandom_range(0, 50);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 9))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 20);
            default: b = $urandom;
         endcase
         run_op($sformatf("rnd%0d op%0d %h/%h", i, op, a, b), op, a, b, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
